// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults and shared helpers for the scaled VGA controller.
// Contents: default timing constants, line/frame total, counter width, 10-bit colour expansion.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to count 0..n-1
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Replicate the low bpc bits of c MSB-first until 10 bits are filled
    function automatic logic [9:0] expand10(input logic [9:0] c, input int bpc);
        logic [9:0] r;
        logic [3:0] k;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            k = 4'(bpc - 1 - (i % bpc));
            r = {r[8:0], c[k]};
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register of DEPTH stages, WIDTH bits wide (DEPTH=0 is a wire).
// Ports: clk, resetn (sync, active-low, loads RST_VAL), en (advance one stage), d (in), q (delayed out).
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];
        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end
        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_xy_scaled_controller.sv
// vga_xy_scaled_controller: parametrised VGA timing with downscaled x/y memory addressing.
// Ports: CLOCK_50, resetn (sync, active-low); color in from memory (READ_LATENCY pixel clocks after x/y);
//        x/y scaled addresses, frame_start pulse; VGA_CLK/HS/VS/BLANK/SYNC and 10-bit VGA_R/G/B to the DAC.
module vga_xy_scaled_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter int SCALE_LOG2   = 2,
    parameter int X_BITS       = 8,
    parameter int Y_BITS       = 7,
    parameter int BPC          = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [3*BPC-1:0]  color,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              frame_start,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK,
    output logic              VGA_SYNC,
    output logic [9:0]        VGA_R,
    output logic [9:0]        VGA_G,
    output logic [9:0]        VGA_B
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] hcount, h_nxt;
    logic [VW-1:0] vcount, v_nxt;
    logic          started, pix_en, h_wrap, act_nxt;
    logic          act, hs, vs, act_d, hs_d, vs_d;

    assign pix_en   = VGA_CLK;
    assign VGA_SYNC = 1'b0;

    // started is clear only until the first pixel tick, which loads (0,0) so frame 0 begins cleanly
    always_comb begin
        h_wrap  = hcount == H_LAST;
        h_nxt   = (!started || h_wrap) ? '0 : hcount + 1'b1;
        v_nxt   = !started ? '0 : !h_wrap ? vcount : (vcount == V_LAST) ? '0 : vcount + 1'b1;
        act_nxt = int'(h_nxt) < H_ACTIVE && int'(v_nxt) < V_ACTIVE;
        act     = started && int'(hcount) < H_ACTIVE && int'(vcount) < V_ACTIVE;
        hs      = int'(hcount) >= H_ACTIVE + H_FP && int'(hcount) < H_ACTIVE + H_FP + H_SYNC;
        vs      = int'(vcount) >= V_ACTIVE + V_FP && int'(vcount) < V_ACTIVE + V_FP + V_SYNC;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            VGA_CLK     <= 1'b0;
            started     <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            VGA_CLK     <= ~VGA_CLK;
            frame_start <= pix_en && h_nxt == '0 && v_nxt == '0;
            if (pix_en) begin
                started <= 1'b1;
                hcount  <= h_nxt;
                vcount  <= v_nxt;
                // addresses are built from the next count so they change together with it
                x       <= act_nxt ? X_BITS'(h_nxt >> SCALE_LOG2) : '0;
                y       <= act_nxt ? Y_BITS'(v_nxt >> SCALE_LOG2) : '0;
            end
        end
    end

    // flags wait out the memory read so they line up with the returned colour
    vga_delay_line #(
        .WIDTH  (3),
        .DEPTH  (READ_LATENCY),
        .RST_VAL(3'b000)
    ) u_delay (
        .clk   (CLOCK_50),
        .resetn(resetn),
        .en    (pix_en),
        .d     ({act, hs, vs}),
        .q     ({act_d, hs_d, vs_d})
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else if (pix_en) begin
            VGA_HS    <= ~hs_d;
            VGA_VS    <= ~vs_d;
            VGA_BLANK <= act_d;
            VGA_R     <= act_d ? expand10(10'(color[3*BPC-1 -: BPC]), BPC) : '0;
            VGA_G     <= act_d ? expand10(10'(color[2*BPC-1 -: BPC]), BPC) : '0;
            VGA_B     <= act_d ? expand10(10'(color[BPC-1 -: BPC]), BPC) : '0;
        end
    end

endmodule

// File: tb/tb_vga_xy_scaled_controller.sv
// tb_vga_xy_scaled_controller: small-mode timing, scaling, latency alignment and colour expansion checks.
module tb_vga_xy_scaled_controller;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 16, VF = 1, VSW = 2, VB = 2;
    localparam int SL = 2, XB = 8, YB = 7, BPC = 3, RL = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = 2 * HT * VT;

    typedef struct { logic [8:0] col; logic [9:0] r, g, b; } vec_t;
    typedef struct { logic hs, vs, blank; logic [9:0] r, g, b; } out_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [8:0]    color;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic          frame_start, vga_clk, hs_n, vs_n, blank, sync;
    logic [9:0]    r, g, b;

    vec_t tbl [8];
    logic [8:0] mem [RL+1];
    out_t exp_q [$];
    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_xy_scaled_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SCALE_LOG2(SL), .X_BITS(XB), .Y_BITS(YB), .BPC(BPC), .READ_LATENCY(RL)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .color(color), .x(x), .y(y),
        .frame_start(frame_start), .VGA_CLK(vga_clk), .VGA_HS(hs_n), .VGA_VS(vs_n),
        .VGA_BLANK(blank), .VGA_SYNC(sync), .VGA_R(r), .VGA_G(g), .VGA_B(b)
    );

    // image memory: samples x/y on the VGA_CLK rising edge, answer ready RL pixel clocks after that
    always @(posedge vga_clk) begin
        mem[0] <= tbl[(int'(x) + 4 * int'(y)) % 8].col;
        for (int i = 1; i <= RL; i++) mem[i] <= mem[i-1];
    end
    assign color = mem[RL];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        applied++;
        if (got !== want) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_vga_clk"}, vga_clk, 0);
        chk({tag, "_hs"}, hs_n, 1);
        chk({tag, "_vs"}, vs_n, 1);
        chk({tag, "_blank"}, blank, 0);
        chk({tag, "_r"}, r, 0);
        chk({tag, "_g"}, g, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
    endtask

    // Releases reset and follows the DUT cycle by cycle; returns after pixel stop_pix (if >= 0)
    task automatic run(input int ncyc, input int stop_pix);
        int last_fs, p, hc, vc, xe, ye, k;
        logic act;
        out_t e, o;
        last_fs = 0;
        exp_q.delete();
        repeat (RL + 1) exp_q.push_back('{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 10'd0});
        resetn = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            chk("vga_clk", vga_clk, n % 2);
            chk("vga_sync", sync, 0);
            if (frame_start) begin
                if (last_fs == 0) chk("fs_first", n, 2);
                else chk("fs_period", n - last_fs, FRAME);
                last_fs = n;
            end
            if (n % 2 == 1) begin
                chk("fs_odd", frame_start, 0);
            end else begin
                p   = n / 2 - 1;
                hc  = p % HT;
                vc  = (p / HT) % VT;
                act = hc < HA && vc < VA;
                xe  = act ? hc >> SL : 0;
                ye  = act ? vc >> SL : 0;
                chk("x", x, xe);
                chk("y", y, ye);
                chk("frame_start", frame_start, hc == 0 && vc == 0);
                if (hc == 7 && vc == 13) begin
                    chk("x_at_7_13", x, 1);
                    chk("y_at_7_13", y, 3);
                end
                if (hc == HA && vc == 5) chk("x_at_hblank", x, 0);
                e.hs    = !(hc >= HA + HF && hc < HA + HF + HSW);
                e.vs    = !(vc >= VA + VF && vc < VA + VF + VSW);
                e.blank = act;
                k       = (xe + 4 * ye) % 8;
                e.r     = act ? tbl[k].r : 10'd0;
                e.g     = act ? tbl[k].g : 10'd0;
                e.b     = act ? tbl[k].b : 10'd0;
                exp_q.push_back(e);
                o = exp_q.pop_front();
                chk("hs", hs_n, o.hs);
                chk("vs", vs_n, o.vs);
                chk("blank", blank, o.blank);
                chk("r", r, o.r);
                chk("g", g, o.g);
                chk("b", b, o.b);
                if (p == stop_pix) return;
            end
        end
    endtask

    initial begin
        tbl[0] = '{9'b101_000_111, 10'h2DB, 10'h000, 10'h3FF};
        tbl[1] = '{9'b111_111_111, 10'h3FF, 10'h3FF, 10'h3FF};
        tbl[2] = '{9'b000_000_000, 10'h000, 10'h000, 10'h000};
        tbl[3] = '{9'b001_010_100, 10'h092, 10'h124, 10'h249};
        tbl[4] = '{9'b011_110_010, 10'h1B6, 10'h36D, 10'h124};
        tbl[5] = '{9'b100_001_011, 10'h249, 10'h092, 10'h1B6};
        tbl[6] = '{9'b110_101_001, 10'h36D, 10'h2DB, 10'h092};
        tbl[7] = '{9'b010_011_110, 10'h124, 10'h1B6, 10'h36D};
        resetn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        run(4 * FRAME, HT * VT + 10 * HT);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        repeat (3) @(negedge clk);
        chk_reset("midrst_hold");
        run(2 * FRAME + 20, -1);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
